// File: rtl/mem_a_addresses_generator.sv
// ============================================================================
// mem_a_addresses_generator : walks matrix A tile by tile, issues bus-wide
// reads to the A mem ctrl and pushes each returned beat into the A buffer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_a_addresses_generator #(
    parameter int BUS_WIDTH_BYTES  = 32,
    parameter int DATA_WIDTH_BYTES = 2,
    parameter int ARRAY_HEIGHT     = 4,
    parameter int ARRAY_WIDTH      = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start_i,
    input  logic [15:0]                  m,
    input  logic [15:0]                  n,
    input  logic [15:0]                  p,
    input  logic [15:0]                  base_addr_a,
    output logic                         do_tran,
    output logic [15:0]                  addr,
    input  logic                         tran_done,
    input  logic [BUS_WIDTH_BYTES*8-1:0] rdata,
    input  logic                         fifo_full,
    output logic                         fifo_push,
    output logic [BUS_WIDTH_BYTES*8-1:0] fifo_wdata,
    output logic                         op_done
);

    localparam int c_COL_STEP = BUS_WIDTH_BYTES / DATA_WIDTH_BYTES;
    localparam int c_SHIFT    = $clog2(DATA_WIDTH_BYTES);

    typedef enum logic [1:0] {
        IDL        = 2'd0,
        WAIT_SPACE = 2'd1,
        READ_DATA  = 2'd2,
        PUSH       = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [15:0] r_row;
    logic [15:0] r_k;
    logic [15:0] r_col_m;
    logic [15:0] r_row_m;
    logic [BUS_WIDTH_BYTES*8-1:0] r_rdata;

    logic [15:0] w_k_next;
    logic [15:0] w_col_next;
    logic [15:0] w_row_m_next;
    logic        w_row_wrap;
    logic        w_k_wrap;
    logic        w_col_wrap;
    logic        w_last;
    logic [15:0] w_row_abs;
    logic [15:0] w_prod;
    logic [15:0] w_elem;

    assign w_k_next     = r_k + 16'(c_COL_STEP);
    assign w_col_next   = r_col_m + 16'(ARRAY_WIDTH);
    assign w_row_m_next = r_row_m + 16'(ARRAY_HEIGHT);
    assign w_row_wrap   = (r_row == 16'(ARRAY_HEIGHT - 1));
    assign w_k_wrap     = (w_k_next == n);
    assign w_col_wrap   = (w_col_next == p);
    assign w_last       = w_row_wrap && w_k_wrap && w_col_wrap && (w_row_m_next == m);

    // Product and sums intentionally wrap at 16 bits.
    assign w_row_abs = r_row_m + r_row;
    assign w_prod    = w_row_abs * n;
    assign w_elem    = base_addr_a + w_prod + r_k;
    assign addr      = w_elem << c_SHIFT;

    assign fifo_wdata = r_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        fifo_push    = 1'b0;
        op_done      = 1'b0;
        case (r_state)
            IDL: begin
                if (start_i) begin
                    w_state_next = WAIT_SPACE;
                end
            end
            WAIT_SPACE: begin
                if (!fifo_full) begin
                    w_state_next = READ_DATA;
                end
            end
            READ_DATA: begin
                if (tran_done) begin
                    w_state_next = PUSH;
                end
            end
            PUSH: begin
                fifo_push    = 1'b1;
                op_done      = w_last;
                w_state_next = w_last ? IDL : WAIT_SPACE;
            end
            default: begin
                w_state_next = IDL;
            end
        endcase
    end

    // A completing tran_done wins over READ_DATA so one beat gets one request.
    always_ff @(posedge clk) begin
        if (reset) begin
            do_tran <= 1'b0;
        end else if (tran_done) begin
            do_tran <= 1'b0;
        end else if (r_state == READ_DATA) begin
            do_tran <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (tran_done) begin
            r_rdata <= rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || r_state == IDL) begin
            r_row   <= 16'd0;
            r_k     <= 16'd0;
            r_col_m <= 16'd0;
            r_row_m <= 16'd0;
        end else if (r_state == PUSH) begin
            if (!w_row_wrap) begin
                r_row <= r_row + 16'd1;
            end else begin
                r_row <= 16'd0;
                if (!w_k_wrap) begin
                    r_k <= w_k_next;
                end else begin
                    r_k <= 16'd0;
                    if (!w_col_wrap) begin
                        r_col_m <= w_col_next;
                    end else begin
                        r_col_m <= 16'd0;
                        r_row_m <= w_row_m_next;
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_a_addresses_generator.sv
// ============================================================================
// tb_mem_a_addresses_generator : directed bench with a loop-order address model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_a_addresses_generator;

    localparam int BWB = 32;
    localparam int DWB = 2;
    localparam int AH  = 4;
    localparam int AW  = 32;
    localparam int CS  = BWB / DWB;
    localparam int DW  = BWB * 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_i;
    logic [15:0]   m, n, p, base_addr_a;
    logic          do_tran;
    logic [15:0]   addr;
    logic          tran_done;
    logic [DW-1:0] rdata;
    logic          fifo_full;
    logic          fifo_push;
    logic [DW-1:0] fifo_wdata;
    logic          op_done;

    logic resp_td;
    logic stray_td;
    logic resp_en;
    assign tran_done = resp_td | stray_td;

    mem_a_addresses_generator #(
        .BUS_WIDTH_BYTES (BWB),
        .DATA_WIDTH_BYTES(DWB),
        .ARRAY_HEIGHT    (AH),
        .ARRAY_WIDTH     (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start_i    (start_i),
        .m          (m),
        .n          (n),
        .p          (p),
        .base_addr_a(base_addr_a),
        .do_tran    (do_tran),
        .addr       (addr),
        .tran_done  (tran_done),
        .rdata      (rdata),
        .fifo_full  (fifo_full),
        .fifo_push  (fifo_push),
        .fifo_wdata (fifo_wdata),
        .op_done    (op_done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [15:0]   exp_addr[$];
    logic [DW-1:0] exp_data[$];
    int            beat_idx = 0;
    int            op_done_cnt = 0;
    logic          prev_do_tran = 1'b0;
    logic          td_at_edge = 1'b0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected beat addresses straight from the tile loop nest.
    task automatic gen_expected(input int mm, input int nn, input int pp, input int base);
        logic [15:0] e;
        exp_addr.delete();
        for (int rm = 0; rm < mm; rm += AH)
            for (int cm = 0; cm < pp; cm += AW)
                for (int k = 0; k < nn; k += CS)
                    for (int r = 0; r < AH; r++) begin
                        e = 16'(base + (rm + r) * nn + k);
                        exp_addr.push_back(16'(e * DWB));
                    end
    endtask

    // Mem ctrl model: answers two cycles after seeing do_tran.
    initial begin
        int cnt;
        cnt     = 0;
        resp_td = 1'b0;
        rdata   = '0;
        forever begin
            @(negedge clk);
            resp_td = 1'b0;
            if (resp_en && do_tran) begin
                cnt++;
                if (cnt == 2) begin
                    resp_td = 1'b1;
                    rdata   = {8{$urandom()}};
                    exp_data.push_back(rdata);
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    always @(posedge clk) td_at_edge <= tran_done;

    always @(negedge clk) begin
        if (td_at_edge) check("do_tran_clr", DW'(do_tran), DW'(0));
        if (do_tran && !prev_do_tran) begin
            if (beat_idx < exp_addr.size())
                check("rd_addr", DW'(addr), DW'(exp_addr[beat_idx]));
            else
                check("unexpected_read", DW'(1), DW'(0));
        end
        if (fifo_push) begin
            if (beat_idx < exp_addr.size() && exp_data.size() > 0) begin
                check("push_addr", DW'(addr), DW'(exp_addr[beat_idx]));
                check("push_data", fifo_wdata, exp_data.pop_front());
                check("op_done_at_push", DW'(op_done), DW'(beat_idx == exp_addr.size() - 1));
                beat_idx++;
            end else begin
                check("unexpected_push", DW'(1), DW'(0));
            end
        end else begin
            check("op_done_no_push", DW'(op_done), DW'(0));
        end
        if (op_done) op_done_cnt++;
        prev_do_tran = do_tran;
    end

    task automatic start_op(input int mm, input int nn, input int pp, input int base);
        gen_expected(mm, nn, pp, base);
        beat_idx    = 0;
        op_done_cnt = 0;
        exp_data.delete();
        m           = 16'(mm);
        n           = 16'(nn);
        p           = 16'(pp);
        base_addr_a = 16'(base);
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (op_done_cnt == 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) check({name, "_timeout"}, DW'(1), DW'(0));
        repeat (5) @(negedge clk);
        check({name, "_beats"}, DW'(beat_idx), DW'(exp_addr.size()));
        check({name, "_op_done_cnt"}, DW'(op_done_cnt), DW'(1));
        check({name, "_idle_do_tran"}, DW'(do_tran), DW'(0));
    endtask

    task automatic wait_beat(input int idx, input logic need_tran);
        int t;
        t = 0;
        while (!(beat_idx == idx && (!need_tran || do_tran)) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) check("wait_beat_timeout", DW'(1), DW'(0));
    endtask

    initial begin
        logic [15:0] held;
        reset       = 1'b1;
        start_i     = 1'b0;
        fifo_full   = 1'b0;
        stray_td    = 1'b0;
        resp_en     = 1'b1;
        m           = 16'd4;
        n           = 16'd16;
        p           = 16'd32;
        base_addr_a = 16'h0100;
        repeat (3) @(negedge clk);
        check("rst_do_tran", DW'(do_tran), DW'(0));
        check("rst_push", DW'(fifo_push), DW'(0));
        check("rst_op_done", DW'(op_done), DW'(0));
        check("rst_wdata", fifo_wdata, DW'(0));
        check("rst_addr", DW'(addr), DW'(16'h0200));
        reset = 1'b0;

        // Test 1
        start_op(4, 16, 32, 16'h0100);
        check("t1_n", DW'(exp_addr.size()), DW'(4));
        check("t1_a0", DW'(exp_addr[0]), DW'(16'h0200));
        check("t1_a3", DW'(exp_addr[3]), DW'(16'h0260));
        wait_done("t1");

        // Test 2
        start_op(4, 32, 32, 16'h0100);
        check("t2_a3", DW'(exp_addr[3]), DW'(16'h02C0));
        check("t2_a4", DW'(exp_addr[4]), DW'(16'h0220));
        check("t2_a7", DW'(exp_addr[7]), DW'(16'h02E0));
        wait_done("t2");

        // Test 3
        start_op(8, 16, 64, 0);
        check("t3_n", DW'(exp_addr.size()), DW'(16));
        check("t3_a4", DW'(exp_addr[4]), DW'(16'h0000));
        check("t3_a8", DW'(exp_addr[8]), DW'(16'h0080));
        check("t3_a15", DW'(exp_addr[15]), DW'(16'h00E0));
        wait_done("t3");

        // Test 4: buffer full while waiting for space
        start_op(4, 16, 32, 16'h0100);
        wait_beat(1, 1'b0);
        fifo_full = 1'b1;
        @(negedge clk);
        held = addr;
        check("t4_held_addr", DW'(held), DW'(16'h0220));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t4_no_tran", DW'(do_tran), DW'(0));
            check("t4_no_push", DW'(fifo_push), DW'(0));
            check("t4_addr", DW'(addr), DW'(held));
        end
        fifo_full = 1'b0;
        wait_done("t4");

        // Test 5: reset during an outstanding request
        start_op(4, 16, 32, 16'h0100);
        wait_beat(1, 1'b1);
        reset   = 1'b1;
        resp_en = 1'b0;
        @(negedge clk);
        check("t5_do_tran", DW'(do_tran), DW'(0));
        check("t5_op_done", DW'(op_done), DW'(0));
        reset    = 1'b0;
        beat_idx = 0;
        exp_data.delete();
        stray_td = 1'b1;
        @(negedge clk);
        stray_td = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t5_no_push", DW'(fifo_push), DW'(0));
        end
        resp_en = 1'b1;
        start_op(4, 16, 32, 16'h0100);
        wait_beat(0, 1'b1);
        check("t5_restart_addr", DW'(addr), DW'(16'h0200));
        wait_done("t5");

        // Test 6: start mid-operation and tran_done while idle
        start_op(8, 16, 64, 0);
        wait_beat(3, 1'b0);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wait_done("t6");
        stray_td = 1'b1;
        @(negedge clk);
        stray_td = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t6_idle_push", DW'(fifo_push), DW'(0));
            check("t6_idle_tran", DW'(do_tran), DW'(0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_a_addresses_generator.md
Name: mem_a_addresses_generator

Overview:
Read-side counterpart of the C write-back address generator. It walks matrix A in the tile order used by the systolic array. For each tile it issues bus-wide read transactions to the A memory controller and pushes each returned beat into the A data buffer (FIFO) that feeds the array. It sits between the config module (start, m, n, p, base address), the A mem ctrl and the A data buffer.

Parameters:
BUS_WIDTH_BYTES, 32, memory bus width in bytes; one beat is one transaction.
DATA_WIDTH_BYTES, 2, element size in bytes (power of 2).
ARRAY_HEIGHT, 4, systolic array rows (power of 2); A rows per tile.
ARRAY_WIDTH, 32, systolic array columns; C columns per tile, used only for tile repetition over p.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset (clk and reset as named; single clock, synchronous active-high fixed)
start_i  in  1  one-cycle start from config module
m  in  16  rows of A/C, elements
n  in  16  columns of A / rows of B, elements
p  in  16  columns of C, elements
base_addr_a  in  16  A base, element units
do_tran  out  1  read request to A mem ctrl (registered)
addr  out  16  byte address of current beat
tran_done  in  1  one-cycle pulse from mem ctrl, rdata valid in same cycle
rdata  in  BUS_WIDTH_BYTES*8  read data beat
fifo_full  in  1  A data buffer full
fifo_push  out  1  push strobe to A data buffer
fifo_wdata  out  BUS_WIDTH_BYTES*8  beat to buffer
op_done  out  1  one-cycle pulse, last beat pushed

Behaviour:
- COL_STEP = BUS_WIDTH_BYTES/DATA_WIDTH_BYTES elements per beat.
- Legal inputs: m is a nonzero multiple of ARRAY_HEIGHT, p is a nonzero multiple of ARRAY_WIDTH, n is a nonzero multiple of COL_STEP. There is no checking; other values are unsupported.
- FSM states: IDL, WAIT_SPACE, READ_DATA, PUSH.
  - IDL -> WAIT_SPACE on start_i.
  - WAIT_SPACE -> READ_DATA when ~fifo_full.
  - READ_DATA -> PUSH on tran_done.
  - PUSH -> IDL if last beat, else WAIT_SPACE.
- start_i is ignored outside IDL.
- do_tran:
  - Reset value 0.
  - Cleared on tran_done; this has priority.
  - Else set when state==READ_DATA, so it first rises the cycle after READ_DATA is entered.
  - Cleared the cycle after tran_done; the mem ctrl never sees a second request for the same beat.
- rdata is captured into a register on tran_done. fifo_wdata is that register.
- fifo_push = (state==PUSH): exactly one push per beat.
- fifo_full is checked only in WAIT_SPACE. The buffer guarantees that a beat accepted there has space at PUSH.
- Loop order, outermost first:
  1. row_m: 0..m-ARRAY_HEIGHT, step ARRAY_HEIGHT.
  2. col_m: 0..p-ARRAY_WIDTH, step ARRAY_WIDTH. Same A block re-read per C tile column.
  3. k: 0..n-COL_STEP, step COL_STEP.
  4. row: 0..ARRAY_HEIGHT-1.
- All counters advance only in PUSH; the innermost counter wraps first. All are cleared in IDL and on reset.
- Element address = base_addr_a + (row_m+row)*n + k. The product is truncated to 16 bits and all sums wrap mod 2^16.
- addr = element address << log2(DATA_WIDTH_BYTES), truncated to 16 bits. addr is combinational from the counters and stable while do_tran is high.
- Last beat: row==ARRAY_HEIGHT-1, k+COL_STEP==n, col_m+ARRAY_WIDTH==p and row_m+ARRAY_HEIGHT==m.
- op_done = last beat & state==PUSH, coincident with the final fifo_push.
- Reset values: do_tran 0, fifo_push 0, op_done 0, fifo_wdata 0, state IDL, all counters 0.
- Reset mid-operation (including while do_tran is high): the next cycle is IDL with do_tran 0. A late tran_done in IDL is ignored.
- tran_done outside READ_DATA is ignored apart from clearing do_tran.
- Minimum beat time with a 1-cycle mem ctrl response is 4 cycles: WAIT_SPACE, READ_DATA, READ_DATA+do_tran, PUSH.
- Total beats = (m/ARRAY_HEIGHT)*(p/ARRAY_WIDTH)*(n/COL_STEP)*ARRAY_HEIGHT.

Test Plan (defaults, COL_STEP=16, fifo_full=0 unless stated, mem ctrl answers 2 cycles after do_tran):
1. m=4, n=16, p=32, base_addr_a=0x0100, start -> 4 reads at addr 0x0200, 0x0220, 0x0240, 0x0260. There are 4 pushes and fifo_wdata matches each rdata. op_done pulses once with the 4th push, then the block returns to IDL.
2. m=4, n=32, p=32, base 0x0100 -> 8 reads: 0x0200, 0x0240, 0x0280, 0x02C0, then 0x0220, 0x0260, 0x02A0, 0x02E0. op_done is asserted on the 8th push only.
3. m=8, n=16, p=64, base 0 -> the 4-beat block 0x0000..0x0060 twice (col_m repeat), then 0x0080, 0x00A0, 0x00C0, 0x00E0 twice. 16 pushes in total, one op_done.
4. fifo_full held high for 10 cycles in WAIT_SPACE -> no do_tran, no push, addr unchanged. After release the sequence resumes with the same beat.
5. reset asserted while do_tran=1 in test 1, beat 2 -> do_tran and op_done are 0 the next cycle. A stray tran_done causes no push. A new start restarts at 0x0200.
6. start_i pulsed mid-operation and tran_done pulsed while in IDL -> no effect: beat count and order are unchanged and no extra push occurs.
